// File: rtl/multiport_register_file.sv
// Multi-read-port register file with a hardware whole-file clear sequencer.
// Optional write-to-read forwarding under macro REGFILE_BYPASS_EN.
module multiport_register_file #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NRD*AW-1:0] RUrs,
  output logic [NRD*XLEN-1:0] RUout,
  input  logic [AW-1:0]     RUrd,
  input  logic [XLEN-1:0]   RUDatawr,
  input  logic              RUWr,
  input  logic              ClrReq,
  output logic              ClrBusy,
  output logic              ClrDone
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [AW-1:0]   r_idx;
  logic [XLEN-1:0] r_regs [NREGS];
  logic            w_wr_en;
  logic            w_last;

  assign w_last = (r_idx == AW'(NREGS - 1));

  assign w_wr_en = RUWr
                && (r_state == S_IDLE)
                && !((ZERO_REG != 0) && (RUrd == '0));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE)
        r_idx <= '0;
      else if (r_state == S_CLEAR)
        r_idx <= r_idx + 1'b1;
    end
  end

  always_comb begin
    w_next  = r_state;
    ClrBusy = 1'b0;
    ClrDone = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (ClrReq)
          w_next = S_CLEAR;
      end
      S_CLEAR: begin
        ClrBusy = 1'b1;
        if (w_last)
          w_next = S_DONE;
      end
      S_DONE: begin
        ClrBusy = 1'b1;
        ClrDone = 1'b1;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Clear owns the write path; normal writes only land in IDLE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREGS; i++)
        r_regs[i] <= '0;
    end else begin
      if (r_state == S_CLEAR)
        r_regs[r_idx] <= '0;
      else if (w_wr_en)
        r_regs[RUrd] <= RUDatawr;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   w_rs;
    logic [XLEN-1:0] w_val;

    assign w_rs = RUrs[k*AW +: AW];

    always_comb begin
      w_val = r_regs[w_rs];
`ifdef REGFILE_BYPASS_EN
      if (w_wr_en && (RUrd == w_rs))
        w_val = RUDatawr;
`endif
      if ((ZERO_REG != 0) && (w_rs == '0))
        w_val = '0;
    end

    assign RUout[k*XLEN +: XLEN] = w_val;
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// Self-checking bench: random traffic against an array model, plus
// directed scenarios with hand-computed expectations.
module tb_multiport_register_file;

  localparam int XL = 32;
  localparam int NR = 32;
  localparam int NP = 2;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NP*AW-1:0] rs = '0;
  logic [NP*XL-1:0] out;
  logic [AW-1:0]   rd = '0;
  logic [XL-1:0]   wd = '0;
  logic            wr = 1'b0;
  logic            clr = 1'b0;
  logic            busy;
  logic            done;

  logic [15:0]     rs4 = '0;
  logic [63:0]     out4;
  logic [3:0]      rd4 = '0;
  logic [15:0]     wd4 = '0;
  logic            wr4 = 1'b0;
  logic            busy4;
  logic            done4;

  int n_chk = 0;
  int n_err = 0;
  bit en_cmp = 1'b0;

  logic [XL-1:0] mdl [NR];
  int            m_clr = -1;

  always #5 clk = ~clk;

  multiport_register_file #(
    .XLEN(XL), .NREGS(NR), .NRD(NP), .ZERO_REG(1)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .RUrs(rs), .RUout(out),
    .RUrd(rd), .RUDatawr(wd), .RUWr(wr), .ClrReq(clr),
    .ClrBusy(busy), .ClrDone(done)
  );

  multiport_register_file #(
    .XLEN(16), .NREGS(16), .NRD(4), .ZERO_REG(1)
  ) dut4 (
    .CLK(clk), .RST_N(rst_n), .RUrs(rs4), .RUout(out4),
    .RUrd(rd4), .RUDatawr(wd4), .RUWr(wr4), .ClrReq(1'b0),
    .ClrBusy(busy4), .ClrDone(done4)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit wr_eff();
    return wr && (m_clr < 0) && (rd != 0);
  endfunction

  function automatic logic [XL-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_eff() && a == rd) return wd;
`endif
    return mdl[a];
  endfunction

  // Reference model: clear walks an integer index 0..NR-1, then one done cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) mdl[i] = '0;
      m_clr = -1;
    end else if (m_clr < 0) begin
      if (wr_eff()) mdl[rd] = wd;
      if (clr) m_clr = 0;
    end else if (m_clr < NR) begin
      mdl[m_clr] = '0;
      m_clr = m_clr + 1;
    end else begin
      m_clr = -1;
    end
  end

  always @(negedge clk) begin
    if (en_cmp && rst_n) begin
      for (int k = 0; k < NP; k++)
        chk("model_rd", 64'(out[k*XL +: XL]), 64'(exp_rd(rs[k*AW +: AW])));
      chk("model_busy", 64'(busy), 64'(m_clr >= 0));
      chk("model_done", 64'(done), 64'(m_clr == NR));
    end
  end

  task automatic drv(input bit w, input int a, input logic [XL-1:0] d,
                     input int r0, input int r1, input bit c);
    @(posedge clk);
    #1;
    wr  = w;
    rd  = AW'(a);
    wd  = d;
    rs  = {AW'(r1), AW'(r0)};
    clr = c;
  endtask

  int nb;
  int nd;
  int guard;

  initial begin
    #3;
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    #9 rst_n = 1'b1;
    en_cmp = 1'b1;

    drv(1, 5, 32'hDEADBEEF, 5, 5, 0);
    drv(0, 0, 0, 5, 5, 0);
    @(negedge clk);
    chk("r5_p0", 64'(out[31:0]), 64'hDEADBEEF);
    chk("r5_p1", 64'(out[63:32]), 64'hDEADBEEF);

    drv(1, 0, 32'h1234, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("zero_p0", 64'(out[31:0]), 64'd0);
    chk("zero_p1", 64'(out[63:32]), 64'd0);

    drv(1, 7, 32'hA, 0, 0, 0);
    drv(1, 7, 32'hB, 7, 5, 0);
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    chk("byp_same", 64'(out[31:0]), 64'hB);
`else
    chk("byp_same", 64'(out[31:0]), 64'hA);
`endif
    drv(0, 0, 0, 7, 7, 0);
    @(negedge clk);
    chk("byp_next", 64'(out[31:0]), 64'hB);

    for (int i = 1; i < NR; i++)
      drv(1, i, 32'h0101_0101 * i + 32'h10, 0, 0, 0);
    drv(0, 0, 0, 31, 9, 1);
    nb = 0;
    nd = 0;
    guard = 0;
    while (guard < 100 && !(nb > 0 && !busy)) begin
      @(posedge clk);
      #1;
      clr = 1'b0;
      wr  = (guard == 20);
      rd  = 5'd9;
      wd  = 32'h55;
      @(negedge clk);
      if (busy) nb++;
      if (done) nd++;
      guard++;
    end
    chk("clr_busy_cycles", 64'(nb), 64'd33);
    chk("clr_done_pulses", 64'(nd), 64'd1);
    drv(0, 0, 0, 9, 31, 0);
    @(negedge clk);
    chk("clr_r9", 64'(out[31:0]), 64'd0);
    chk("clr_r31", 64'(out[63:32]), 64'd0);

    drv(1, 4, 32'h44, 0, 0, 0);
    drv(1, 20, 32'h20, 4, 20, 0);
    drv(0, 0, 0, 4, 20, 1);
    guard = 0;
    do begin
      drv(0, 0, 0, 4, 20, 0);
      guard++;
    end while (m_clr != 16 && guard < 100);
    chk("mid_idx_reached", 64'(m_clr), 64'd16);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_p0", 64'(out[31:0]), 64'd0);
    chk("mid_rst_p1", 64'(out[63:32]), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drv(1, 6, 32'h66, 6, 20, 0);
    drv(0, 0, 0, 6, 20, 0);
    @(negedge clk);
    chk("post_rst_wr", 64'(out[31:0]), 64'h66);
    chk("post_rst_r20", 64'(out[63:32]), 64'd0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("no_done_after_abort", 64'(nd), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      wr  = ($urandom_range(0, 3) != 0);
      rd  = AW'($urandom_range(0, NR - 1));
      wd  = $urandom;
      rs  = NP*AW'($urandom);
      if ($urandom_range(0, 3) == 0) rs[AW-1:0] = rd;
      clr = ($urandom_range(0, 99) == 0);
    end
    drv(0, 0, 0, 0, 0, 0);
    guard = 0;
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end

    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      wr4 = 1'b1;
      rd4 = (i == 3) ? 4'd15 : 4'(i + 1);
      wd4 = 16'h1111 * 16'(i + 1) + 16'h0F;
    end
    @(posedge clk);
    #1;
    wr4 = 1'b0;
    rs4 = {4'd15, 4'd3, 4'd2, 4'd1};
    @(negedge clk);
    chk("p4_r1", 64'(out4[15:0]), 64'h1120);
    chk("p4_r2", 64'(out4[31:16]), 64'h2231);
    chk("p4_r3", 64'(out4[47:32]), 64'h3342);
    chk("p4_r15", 64'(out4[63:48]), 64'h4453);
    chk("p4_busy", 64'(busy4), 64'd0);

    en_cmp = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/multiport_register_file.md
MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

Interface
REQ-001 SHALL have parameter XLEN, 32, register width in bits.
REQ-002 SHALL have parameter NREGS, 32, number of registers (power of two, >=4); AW = log2(NREGS).
REQ-003 SHALL have parameter NRD, 2, number of independent read ports (1..4).
REQ-004 SHALL have parameter ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes.
REQ-005 SHALL have port CLK  input  1  the single clock; all state updates on rising edge.
REQ-006 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port RUrs  input  NRD*AW  packed read addresses; port k uses bits [k*AW +: AW].
REQ-008 SHALL have port RUout  output  NRD*XLEN  packed read data; port k uses bits [k*XLEN +: XLEN].
REQ-009 SHALL have port RUrd  input  AW  write address.
REQ-010 SHALL have port RUDatawr  input  XLEN  write data.
REQ-011 SHALL have port RUWr  input  1  write enable.
REQ-012 SHALL have port ClrReq  input  1  request to zero the whole file.
REQ-013 SHALL have port ClrBusy  output  1  high while a clear sequence is in progress.
REQ-014 SHALL have port ClrDone  output  1  one-cycle pulse on clear completion.

Function
REQ-015 SHALL provide combinational reads: RUout port k = contents of RUrs port k, zero-latency, all ports independent, including identical addresses.
REQ-016 SHALL read address 0 as zero on every port when ZERO_REG=1, regardless of stored value.
REQ-017 SHALL write RUDatawr to RUrd on rising CLK when RUWr=1, FSM in IDLE, and not (ZERO_REG=1 and RUrd=0).
REQ-018 SHALL drop (never queue) writes presented while ClrBusy=1.
REQ-019 SHALL implement FSM states IDLE, CLEAR, DONE; reset state IDLE.
REQ-020 SHALL move IDLE->CLEAR on a rising edge with ClrReq=1, loading clear index 0; a simultaneous RUWr in that cycle SHALL be performed (clear overwrites it later).
REQ-021 SHALL in CLEAR zero register[index] each cycle and increment index; after index NREGS-1 is zeroed, move to DONE (CLEAR lasts exactly NREGS cycles).
REQ-022 SHALL in DONE assert ClrDone for exactly one cycle, then return to IDLE.
REQ-023 SHALL ignore ClrReq while in CLEAR or DONE; ClrReq held high in IDLE after DONE SHALL start a new sequence.
REQ-024 SHALL drive ClrBusy=1 exactly in CLEAR and DONE states.
REQ-025 SHALL return current (partially cleared) contents on reads during CLEAR.

Reset
REQ-026 SHALL on RST_N=0, asynchronously: all registers to 0, FSM to IDLE, clear index to 0, ClrBusy=0, ClrDone=0.
REQ-027 SHALL abort a clear in progress on reset, with no ClrDone pulse.
REQ-028 SHALL accept writes from the first rising CLK after RST_N deasserts.

Configuration
REQ-029 SHALL, with macro REGFILE_BYPASS_EN defined, forward RUDatawr to any read port whose address equals RUrd in a cycle where the write of REQ-017 will take effect.
REQ-030 SHALL, without REGFILE_BYPASS_EN, return the stored (pre-write) value in that case; forwarding never applies to dropped writes or to register 0 under ZERO_REG=1.

Verification
REQ-031 SHALL cover: reset, write 32'hDEADBEEF to reg 5, next cycle read on both ports -> both 32'hDEADBEEF.
REQ-032 SHALL cover: ZERO_REG=1, write 32'h1234 to reg 0 -> reads of reg 0 return 0 on all ports.
REQ-033 SHALL cover: reg 7=32'hA, same cycle write 32'hB to reg 7 with RUrs port0=7 -> 32'hB with REGFILE_BYPASS_EN, 32'hA without; next cycle 32'hB in both builds.
REQ-034 SHALL cover: all regs nonzero, pulse ClrReq -> ClrBusy high NREGS+1 cycles, ClrDone single pulse one cycle after last zeroing, all regs 0; write issued during CLEAR absent afterwards.
REQ-035 SHALL cover: RST_N asserted at index NREGS/2 of CLEAR -> all outputs 0 immediately, FSM IDLE, no ClrDone.
REQ-036 SHALL cover: NRD=4, NREGS=16, XLEN=16, four ports reading distinct regs 1,2,3,15 -> each returns its own written value.
